dglk_pbk_interp: RTL and testbench

DGLK_PBK_INTERP -- requirements
Module: dglk_pbk_interp

---
 rtl/dglk_pbk_interp_if.sv | 24 ++
 rtl/dglk_pbk_interp.sv | 160 ++++++++++++++++
 tb/tb_dglk_pbk_interp.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dglk_pbk_interp_if.sv
// Playback interpolator bus: control levels, upstream sample request/return, DAC output.
// The master side drives control and upstream samples; the interpolator side is the slave.
interface dglk_pbk_interp_if #(
  parameter int W_PBK = 16
);
  logic                    ena;
  logic [3:0]              log2_per;
  logic                    hold;
  logic signed [W_PBK-1:0] smp_in;
  logic                    smp_req;
  logic signed [W_PBK-1:0] dac_out;
  logic                    out_vld;
  logic                    underrun;

  modport master (
    output ena, log2_per, hold, smp_in,
    input  smp_req, dac_out, out_vld, underrun
  );

  modport slave (
    input  ena, log2_per, hold, smp_in,
    output smp_req, dac_out, out_vld, underrun
  );
endinterface

// File: rtl/dglk_pbk_interp.sv
// Linear/zero-order playback interpolator: prefetches samples into a small FIFO, ramps between them over 2^k cycles.
// dac_out is registered (one cycle after acc); requests throttle so FIFO + in-flight never exceed DEPTH.
module dglk_pbk_interp #(
  parameter int W_PBK = 16,
  parameter int LAT   = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dglk_pbk_interp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WA = W_PBK + 17;
  localparam int WD = W_PBK + 1;

  typedef enum logic [1:0] {IDLE, P0, P1, RUN} state_t;
  state_t state, state_nxt;

  logic [LAT-1:0]          inflt, live;
  logic signed [W_PBK-1:0] mem [DEPTH];
  logic [AW-1:0]           wp, rp;
  logic [CW-1:0]           cnt;
  logic [3:0]              live_cnt;
  logic [7:0]              occ;
  logic                    push, pop, fifo_ne, dead, req, seg_end;
  logic signed [W_PBK-1:0] head, s0, s1;
  logic signed [WD-1:0]    delta, delta_eff;
  logic signed [WA-1:0]    acc;
  logic [15:0]             phase;
  logic [3:0]              k_q;

  function automatic logic signed [WA-1:0] scale(input logic signed [W_PBK-1:0] v, input logic [3:0] k);
    return WA'(v) <<< k;
  endfunction

  always_comb begin
    live_cnt = '0;
    for (int i = 0; i < LAT; i++) live_cnt = live_cnt + 4'(live[i]);
  end

  // Killed requests (issued before ena dropped) must drain before new ones go out.
  assign dead      = |(inflt & ~live);
  assign occ       = 8'(cnt) + 8'(live_cnt);
  assign req       = bus.ena && (state != IDLE) && !dead && (occ < 8'(DEPTH));
  assign push      = live[LAT-1] && bus.ena;
  assign fifo_ne   = (cnt != '0);
  assign head      = mem[rp];
  assign seg_end   = (phase == ((16'd1 << k_q) - 16'd1));
  assign delta_eff = bus.hold ? '0 : delta;
  assign bus.smp_req = req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflt <= '0;
      live  <= '0;
    end else begin
      inflt <= (inflt << 1) | LAT'(req);
      live  <= bus.ena ? ((live << 1) | LAT'(req)) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.smp_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (!bus.ena) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (!bus.ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = P0;
        P0: if (fifo_ne) begin
          pop       = 1'b1;
          state_nxt = P1;
        end
        P1: if (fifo_ne) begin
          pop       = 1'b1;
          state_nxt = RUN;
        end
        RUN:     pop = seg_end && fifo_ne;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0           <= '0;
      s1           <= '0;
      delta        <= '0;
      acc          <= '0;
      phase        <= '0;
      k_q          <= '0;
      bus.dac_out  <= '0;
      bus.out_vld  <= 1'b0;
      bus.underrun <= 1'b0;
    end else begin
      bus.out_vld <= (state == RUN) && bus.ena;
      if (state == IDLE && bus.ena) bus.underrun <= 1'b0;
      case (state)
        P0: if (pop) begin
          s0  <= head;
          acc <= scale(head, bus.log2_per);
        end
        P1: if (pop) begin
          s1    <= head;
          delta <= WD'(head) - WD'(s0);
          phase <= '0;
          k_q   <= bus.log2_per;
          acc   <= scale(s0, bus.log2_per);
        end
        RUN: if (bus.ena) begin
          bus.dac_out <= W_PBK'(acc >>> k_q);
          // Segment end rebases acc on the next sample so rounding error never accumulates.
          if (seg_end) begin
            s0    <= s1;
            acc   <= scale(s1, bus.log2_per);
            phase <= '0;
            k_q   <= bus.log2_per;
            if (fifo_ne) begin
              s1    <= head;
              delta <= WD'(head) - WD'(s1);
            end else begin
              delta        <= '0;
              bus.underrun <= 1'b1;
            end
          end else begin
            acc   <= acc + WA'(delta_eff);
            phase <= phase + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dglk_pbk_interp.sv
// Bench for dglk_pbk_interp: directed vector table, corner sequences, and random runs against an ideal ramp model.
module tb_dglk_pbk_interp;
  localparam int W = 16, LAT = 4, DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dglk_pbk_interp_if #(.W_PBK(W)) bus ();
  dglk_pbk_interp #(.W_PBK(W), .LAT(LAT), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0, n_fail = 0;
  int src_q[$];
  int last_src = 0;
  bit req_p [LAT+1];
  int val_p [LAT+1];
  bit mon_on = 0;
  int max_outst = 0;
  int got[$];

  // Upstream playback: value bound at request time, returned exactly LAT cycles later; garbage otherwise.
  always @(negedge clk) begin
    int outst;
    for (int i = LAT; i > 0; i--) begin
      req_p[i] = req_p[i-1];
      val_p[i] = val_p[i-1];
    end
    req_p[0] = bus.smp_req;
    val_p[0] = 0;
    if (bus.smp_req) begin
      if (src_q.size() > 0) last_src = src_q.pop_front();
      val_p[0] = last_src;
    end
    bus.smp_in = req_p[LAT] ? W'(val_p[LAT]) : W'($urandom);
    outst = 0;
    for (int i = 0; i <= LAT; i++) outst += int'(req_p[i]);
    if (mon_on && outst > max_outst) max_outst = outst;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.ena = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n, input string tag);
    int budget;
    bit started, gap;
    budget = 400;
    started = 0;
    gap = 0;
    got.delete();
    while (got.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (bus.out_vld) begin
        started = 1;
        got.push_back(int'(bus.dac_out));
      end else if (started) gap = 1;
    end
    check({tag, "_cnt"}, got.size(), n);
    check({tag, "_vld_cont"}, gap, 0);
  endtask

  function automatic int smp_at(input int s[$], input int j);
    return (j < s.size()) ? s[j] : s[s.size()-1];
  endfunction

  // Ideal output n: straight line from s[j] to s[j+1] across 2^k steps, floored.
  function automatic int model(input int s[$], input int k, input bit h, input int n);
    int j, i;
    longint a, b;
    j = n >> k;
    i = n - (j << k);
    a = smp_at(s, j);
    b = smp_at(s, j + 1);
    if (h) return int'(a);
    return int'(((a <<< k) + longint'(i) * (b - a)) >>> k);
  endfunction

  function automatic int got_at(input int i);
    return (i < got.size()) ? got[i] : -99999;
  endfunction

  typedef struct {
    int k;
    bit hold;
    int smp[4];
    int n_exp;
    int expv[9];
  } vec_t;
  vec_t vecs[5];

  initial begin
    int frz;
    bit dropped;
    int s[$];
    int k, n;
    bit h;
    logic signed [15:0] tmp;

    vecs[0] = '{2, 1'b0, '{0, 100, 200, 300}, 9, '{0, 25, 50, 75, 100, 125, 150, 175, 200}};
    vecs[1] = '{1, 1'b0, '{100, -100, 0, 0}, 5, '{100, 0, -100, -50, 0, 0, 0, 0, 0}};
    vecs[2] = '{1, 1'b0, '{0, 3, 3, 3}, 3, '{0, 1, 3, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{1, 1'b0, '{0, -3, -3, -3}, 3, '{0, -2, -3, 0, 0, 0, 0, 0, 0}};
    vecs[4] = '{2, 1'b1, '{10, 20, 20, 20}, 8, '{10, 10, 10, 10, 20, 20, 20, 20, 0}};

    bus.log2_per = 4'd2;
    bus.hold = 1'b0;
    do_reset();
    check("rst_dac", int'(bus.dac_out), 0);
    check("rst_vld", bus.out_vld, 0);
    check("rst_req", bus.smp_req, 0);
    check("rst_und", bus.underrun, 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      bus.log2_per = 4'(vecs[v].k);
      bus.hold = vecs[v].hold;
      src_q.delete();
      for (int i = 0; i < 4; i++) src_q.push_back(vecs[v].smp[i]);
      bus.ena = 1'b1;
      collect(vecs[v].n_exp, $sformatf("vec%0d", v));
      for (int i = 0; i < vecs[v].n_exp; i++)
        check($sformatf("vec%0d_out%0d", v, i), got_at(i), vecs[v].expv[i]);
    end

    // Sample starvation at k=0: last value held, sticky underrun, bounded outstanding requests.
    do_reset();
    bus.log2_per = 4'd0;
    bus.hold = 1'b0;
    src_q = '{7, 8, 9};
    max_outst = 0;
    mon_on = 1;
    bus.ena = 1'b1;
    repeat (40) @(negedge clk);
    check("und_dac", int'(bus.dac_out), 9);
    check("und_flag", bus.underrun, 1);
    check("und_vld", bus.out_vld, 1);
    dropped = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.underrun) dropped = 1;
    end
    check("und_sticky", dropped, 0);
    mon_on = 0;
    check("und_outst_le_depth", (max_outst <= DEPTH), 1);
    @(posedge clk); #1 bus.ena = 1'b0;
    @(posedge clk); #1;
    check("und_idle_keep", bus.underrun, 1);
    bus.log2_per = 4'd3;
    bus.ena = 1'b1;
    @(posedge clk); #1;
    check("und_clr_p0", bus.underrun, 0);

    // ena dropped mid-RUN, then re-enabled with a fresh stream.
    do_reset();
    bus.log2_per = 4'd2;
    src_q = '{1000, 2000, 3000, 4000, 5000, 6000};
    bus.ena = 1'b1;
    collect(6, "pre");
    for (int i = 0; i < 6; i++) check($sformatf("pre_out%0d", i), got_at(i), 1000 + 250 * i);
    @(posedge clk); #1 bus.ena = 1'b0;
    @(posedge clk); #1;
    check("drop_vld", bus.out_vld, 0);
    check("drop_req", bus.smp_req, 0);
    check("drop_frz", int'(bus.dac_out), 2500);
    @(posedge clk); #1;
    check("drop_frz2", int'(bus.dac_out), 2500);
    src_q = '{-500, -300, -100};
    bus.ena = 1'b1;
    collect(5, "reen");
    for (int i = 0; i < 5; i++) check($sformatf("reen_out%0d", i), got_at(i), -500 + 50 * i);

    // Asynchronous reset mid-segment.
    do_reset();
    bus.log2_per = 4'd3;
    src_q = '{0, 800, 1600};
    bus.ena = 1'b1;
    collect(3, "arst_pre");
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("arst_dac", int'(bus.dac_out), 0);
    check("arst_vld", bus.out_vld, 0);
    check("arst_req", bus.smp_req, 0);
    check("arst_und", bus.underrun, 0);
    bus.log2_per = 4'd2;
    src_q = '{40, 80, 120};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("arst_rel_req", bus.smp_req, 0);
    collect(5, "arst_post");
    for (int i = 0; i < 5; i++) check($sformatf("arst_out%0d", i), got_at(i), 40 + 10 * i);

    // Random streams against the ideal ramp model.
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(1, 3);
      h = 1'($urandom_range(0, 1));
      s.delete();
      for (int i = 0; i < 8; i++) begin
        tmp = 16'($urandom);
        s.push_back(int'(tmp));
      end
      do_reset();
      bus.log2_per = 4'(k);
      bus.hold = h;
      src_q = s;
      bus.ena = 1'b1;
      n = 3 << k;
      collect(n, $sformatf("rnd%0d", r));
      for (int i = 0; i < n; i++)
        check($sformatf("rnd%0d_k%0d_h%0d_out%0d", r, k, h, i), got_at(i), model(s, k, h, i));
      check($sformatf("rnd%0d_und", r), bus.underrun, 0);
    end

    bus.ena = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
